// File: rtl/fifo_prog_thresh.sv
// fifo_prog_thresh: single-clock FIFO with thresholds programmed in an INIT
// state, an error state entered on overflow/underflow, registered read data,
// and occupancy-derived status flags.
//
// Ports:
//   clk                          rising-edge clock
//   reset_L                      asynchronous active-low reset
//   init                         enter INIT (flush FIFO, clear error)
//   almost_empty_threshold_input almost-empty level, latched while in INIT
//   almost_full_threshold_input  almost-full level, latched while in INIT
//   wr_en / data_in              write request and data
//   rd_en                        read request
//   data_out / valid_out         registered read data, valid for one cycle
//   empty_flag, full_flag, almost_empty_flag, almost_full_flag, error_flag
//   count                        occupancy 0..FIFO_DEPTH
//   state                        INIT=0, IDLE=1, ACTIVE=2, ERROR=3
module fifo_prog_thresh #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      init,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold_input,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold_input,
    input  logic                      wr_en,
    input  logic [FIFO_WORD_SIZE-1:0] data_in,
    input  logic                      rd_en,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid_out,
    output logic                      empty_flag,
    output logic                      full_flag,
    output logic                      almost_empty_flag,
    output logic                      almost_full_flag,
    output logic                      error_flag,
    output logic [FIFO_PTR_SIZE:0]    count,
    output logic [1:0]                state
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    localparam logic [FIFO_PTR_SIZE:0]   LP_DEPTH  = (FIFO_PTR_SIZE+1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_SIZE-1:0] LP_AE_RST = FIFO_PTR_SIZE'(FIFO_DEPTH / 4);
    localparam logic [FIFO_PTR_SIZE-1:0] LP_AF_RST = FIFO_PTR_SIZE'(FIFO_DEPTH - FIFO_DEPTH / 4);

    logic [1:0]                r_state;
    logic [FIFO_PTR_SIZE-1:0]  r_wr_ptr;
    logic [FIFO_PTR_SIZE-1:0]  r_rd_ptr;
    logic [FIFO_PTR_SIZE:0]    r_count;
    logic [FIFO_WORD_SIZE-1:0] r_data_out;
    logic                      r_valid;
    logic                      r_error;
    logic [FIFO_PTR_SIZE-1:0]  r_ae_th;
    logic [FIFO_PTR_SIZE-1:0]  r_af_th;
    logic [FIFO_WORD_SIZE-1:0] r_mem [FIFO_DEPTH];

    logic                      w_run;
    logic                      w_underflow;
    logic                      w_overflow;
    logic                      w_err;
    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic [FIFO_PTR_SIZE:0]    w_count_next;

    // Accesses are only considered in IDLE/ACTIVE and never on an init cycle.
    // Once no error is detected, a write at full implies a read in the same
    // cycle, and a read implies count>0, so acceptance reduces to the request.
    always_comb begin
        w_run        = !init && (r_state == ST_IDLE || r_state == ST_ACTIVE);
        w_underflow  = w_run && rd_en && (r_count == '0);
        w_overflow   = w_run && wr_en && !rd_en && (r_count == LP_DEPTH);
        w_err        = w_underflow || w_overflow;
        w_wr_acc     = w_run && !w_err && wr_en;
        w_rd_acc     = w_run && !w_err && rd_en;
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc)
            w_count_next = r_count + 1'b1;
        else if (w_rd_acc && !w_wr_acc)
            w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ST_INIT;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_ae_th    <= LP_AE_RST;
            r_af_th    <= LP_AF_RST;
        end else begin
            // Thresholds track the inputs on every cycle spent in INIT,
            // including the cycle that leaves it.
            if (r_state == ST_INIT) begin
                r_ae_th <= almost_empty_threshold_input;
                r_af_th <= almost_full_threshold_input;
            end

            if (init) begin
                r_state  <= ST_INIT;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_error  <= 1'b0;
                r_valid  <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                    ST_IDLE, ST_ACTIVE: begin
                        if (w_err) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            if (w_wr_acc)
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (w_rd_acc) begin
                                r_rd_ptr   <= r_rd_ptr + 1'b1;
                                r_data_out <= r_mem[r_rd_ptr];
                                r_valid    <= 1'b1;
                            end else begin
                                r_valid <= 1'b0;
                            end
                            r_count <= w_count_next;
                            r_state <= (w_wr_acc || w_count_next != '0) ? ST_ACTIVE : ST_IDLE;
                        end
                    end
                    ST_ERROR: begin
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_INIT;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= data_in;
    end

    assign data_out          = r_data_out;
    assign valid_out         = r_valid;
    assign error_flag        = r_error;
    assign count             = r_count;
    assign state             = r_state;
    assign empty_flag        = (r_count == '0);
    assign full_flag         = (r_count == LP_DEPTH);
    assign almost_empty_flag = (r_count != '0) && (r_count <= {1'b0, r_ae_th});
    assign almost_full_flag  = !full_flag && (r_af_th != '0) && (r_count >= {1'b0, r_af_th});

endmodule

// File: doc/fifo_prog_thresh.md
FIFO_PROG_THRESH -- requirements
Module: fifo_prog_thresh

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 8, number of entries; must be a power of 2 and at least 4.
REQ-002 SHALL have parameter FIFO_WORD_SIZE, 10, data width in bits.
REQ-003 SHALL have parameter FIFO_PTR_SIZE, $clog2(FIFO_DEPTH), pointer and threshold width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port init  input  1  requests threshold-programming state and flushes the FIFO.
REQ-007 SHALL have port almost_empty_threshold_input  input  FIFO_PTR_SIZE  almost-empty level, sampled in INIT.
REQ-008 SHALL have port almost_full_threshold_input  input  FIFO_PTR_SIZE  almost-full level, sampled in INIT.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port data_in  input  FIFO_WORD_SIZE  write data.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port data_out  output  FIFO_WORD_SIZE  registered read data.
REQ-013 SHALL have port valid_out  output  1  data_out updated this cycle.
REQ-014 SHALL have ports empty_flag, full_flag, almost_empty_flag, almost_full_flag, error_flag  output  1 each  status flags.
REQ-015 SHALL have port count  output  FIFO_PTR_SIZE+1  current occupancy, range 0..FIFO_DEPTH.
REQ-016 SHALL have port state  output  2  FSM state: INIT=0, IDLE=1, ACTIVE=2, ERROR=3.

Function
REQ-017 SHALL implement FSM INIT, IDLE, ACTIVE, ERROR; init=1 in any state forces INIT on the next edge, flushing pointers and setting count to 0.
REQ-018 SHALL, in INIT, latch both threshold inputs every cycle; init=0 moves to IDLE; wr_en and rd_en are ignored.
REQ-019 SHALL move from IDLE to ACTIVE on the first accepted write, and from ACTIVE to IDLE when count returns to 0 without error.
REQ-020 SHALL accept a write when wr_en=1 in IDLE/ACTIVE and count<FIFO_DEPTH, or when count=FIFO_DEPTH with rd_en=1 in the same cycle.
REQ-021 SHALL accept a read when rd_en=1 in ACTIVE and count>0; data_out and valid_out=1 follow on the edge after rd_en (1-cycle latency), strictly in FIFO order.
REQ-022 SHALL, for simultaneous accepted read and write, leave count unchanged; there is no write-to-read bypass when empty.
REQ-023 SHALL treat the following as errors: overflow (write at count=FIFO_DEPTH without read) or underflow (rd_en=1 at count=0, including simultaneous wr_en).
REQ-024 SHALL, on error, drop the offending access, set error_flag=1 (sticky), and enter ERROR.
REQ-025 SHALL, in ERROR, ignore wr_en and rd_en and hold count and data; only init=1 or reset exits ERROR, and both clear error_flag.
REQ-026 SHALL hold data_out at its last value with valid_out=0 on cycles without an accepted read.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-028 SHALL derive flags from registered count: empty_flag = (count==0); full_flag = (count==FIFO_DEPTH).
REQ-029 SHALL set almost_empty_flag = (count!=0 && count<=ae_th) and almost_full_flag = (!full_flag && af_th!=0 && count>=af_th); a threshold of 0 disables its flag.

Reset
REQ-030 SHALL, while reset_L=0, immediately (asynchronously) set: state=INIT, pointers=0, count=0, data_out=0, valid_out=0, error_flag=0, empty_flag=1, all other flags 0.
REQ-031 SHALL, on reset, set latched thresholds to ae_th=FIFO_DEPTH/4 and af_th=FIFO_DEPTH-FIFO_DEPTH/4; reset mid-operation discards all stored data.

Verification
REQ-032 SHALL cover: reset, init=1 with ae=2/af=6, init=0, write 1..8 -> almost_full at count 6,7; full_flag at 8; a 9th write gives error_flag=1, state=3, count=8.
REQ-033 SHALL cover: after a re-init, write 1..8 then read 8 -> data_out 1..8 with valid_out one cycle after each rd_en; almost_empty at count 2,1; empty_flag and state=IDLE at end.
REQ-034 SHALL cover: at count=8, simultaneous wr_en/rd_en with data 9 -> count stays 8, no error, data_out=1, and 9 is later read last.
REQ-035 SHALL cover: read at count=0 -> error_flag=1, state=ERROR; init=1 then 0 -> state INIT then IDLE, error_flag=0, count=0.
REQ-036 SHALL cover: reset_L=0 asynchronously at count=5 -> outputs reset before the next edge; thresholds return to 2/6.
REQ-037 SHALL cover: write 5, read 5, write 8, read 8 -> pointers wrap and all 13 words are read back in order.
